// File: rtl/fb_arb_pkg.sv
// Shared types and helpers for the framebuffer write arbiter.
// The round-robin helper is sized for up to 8 requesters so that other
// arbiters can reuse it with their own requester counts.
package fb_arb_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int PIXEL_W = 24;

    // One-hot pick of the first valid requester, scanning last+1, last+2, ...
    // modulo num. Returns all zeros when nothing in range is valid.
    function automatic logic [7:0] rr_next(
        input logic [7:0] valid,
        input logic [2:0] last,
        input logic [3:0] num
    );
        logic [7:0] grant;
        logic [4:0] slot;
        logic       found;
        grant = 8'd0;
        found = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            slot = 5'(last) + 5'(k);
            if (slot >= 5'(num)) begin
                slot = slot - 5'(num);
            end else begin
                slot = slot;
            end
            if (!found && (k <= int'(num)) && valid[slot[2:0]]) begin
                grant[slot[2:0]] = 1'b1;
                found            = 1'b1;
            end else begin
                found = found;
            end
        end
        return grant;
    endfunction

endpackage

// File: rtl/fb_write_arbiter_rr_pick.sv
// Combinational round-robin picker: valid vector plus last-served index in,
// one-hot grant, binary grant index and "anything granted" out.
module rr_pick
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ = 3,
    parameter int IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] valid,
    input  logic [IDX_W-1:0]   last,
    output logic [NUM_REQ-1:0] grant,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [7:0] valid_pad_s;
    logic [7:0] grant_pad_s;

    // Widen to the helper's fixed size, pick, then encode the winner index.
    always_comb begin
        valid_pad_s                = 8'd0;
        valid_pad_s[NUM_REQ-1:0]   = valid;
        grant_pad_s                = rr_next(valid_pad_s, 3'(last), 4'(NUM_REQ));
        grant                      = grant_pad_s[NUM_REQ-1:0];
        any                        = |grant_pad_s;
        idx                        = {IDX_W{1'b0}};
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = idx | (grant_pad_s[k] ? IDX_W'(k) : {IDX_W{1'b0}});
        end
    end

endmodule

// File: rtl/fb_write_arbiter.sv
// Framebuffer write-port arbiter: round-robin between pixel writers with a
// burst lock so one owner's sprite draw stays contiguous, registered write
// port towards the pixel RAM and a per-frame saturating write counter.
// Build option: define FB_ARB_VBLANK_GATE_EN to only allow writes while
// vblank is high (tear-free updates); otherwise writes are never gated.
module fb_write_arbiter
    import fb_arb_pkg::*;
#(
    parameter int NUM_REQ   = 3,
    parameter int ADDR_W    = 19,
    parameter int DATA_W    = PIXEL_W,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk_clk,
    input  logic                      reset_reset,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      vblank,
    output logic                      fb_we,
    output logic [ADDR_W-1:0]         fb_addr,
    output logic [DATA_W-1:0]         fb_data,
    output logic [15:0]               wr_count
);

    localparam int               IDX_W     = $clog2(NUM_REQ);
    localparam logic [7:0]       BURST_MAX = 8'(MAX_BURST);
    localparam logic [IDX_W-1:0] LAST_RST  = IDX_W'(NUM_REQ - 1);

    arb_state_e          state_r, next_state_s;
    logic [IDX_W-1:0]    last_r, next_last_s;
    logic [IDX_W-1:0]    owner_r, next_owner_s;
    logic [7:0]          burst_cnt_r, next_cnt_s;
    logic [NUM_REQ-1:0]  pick_grant_s, owner_oh_s, ready_s;
    logic [IDX_W-1:0]    pick_idx_s, accept_idx_s;
    logic                pick_any_s, gate_s, accept_s, owner_valid_s;
    logic                vblank_q_r, vblank_rise_s;
    logic                fb_we_r;
    logic [ADDR_W-1:0]   fb_addr_r;
    logic [DATA_W-1:0]   fb_data_r;
    logic [15:0]         wr_count_r;

`ifdef FB_ARB_VBLANK_GATE_EN
    assign gate_s = vblank;
`else
    assign gate_s = 1'b1;
`endif

    assign owner_oh_s    = {{(NUM_REQ-1){1'b0}}, 1'b1} << owner_r;
    assign owner_valid_s = |(req_valid & owner_oh_s);
    assign vblank_rise_s = vblank & ~vblank_q_r;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_pick (
        .valid (req_valid),
        .last  (last_r),
        .grant (pick_grant_s),
        .idx   (pick_idx_s),
        .any   (pick_any_s)
    );

    // FSM state, round-robin pointer, burst owner and beat counter.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            state_r     <= IDLE;
            last_r      <= LAST_RST;
            owner_r     <= {IDX_W{1'b0}};
            burst_cnt_r <= 8'd0;
        end else begin
            state_r     <= next_state_s;
            last_r      <= next_last_s;
            owner_r     <= next_owner_s;
            burst_cnt_r <= next_cnt_s;
        end
    end

    // Next-state: start a burst on a grant, release on burst limit, owner
    // idle or closed gate (the release cycle is a bubble with no accept).
    always_comb begin
        next_state_s = state_r;
        next_last_s  = last_r;
        next_owner_s = owner_r;
        next_cnt_s   = burst_cnt_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    next_owner_s = pick_idx_s;
                    next_cnt_s   = 8'd1;
                    if (MAX_BURST > 1) begin
                        next_state_s = BURST;
                    end else begin
                        next_state_s = IDLE;
                        next_last_s  = pick_idx_s;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            BURST: begin
                if (accept_s) begin
                    next_cnt_s = burst_cnt_r + 8'd1;
                    if ((burst_cnt_r + 8'd1) == BURST_MAX) begin
                        next_state_s = IDLE;
                        next_last_s  = owner_r;
                    end else begin
                        next_state_s = BURST;
                    end
                end else begin
                    next_state_s = IDLE;
                    next_last_s  = owner_r;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Handshake: ready only to the picked requester in IDLE or to the
    // locked owner in BURST, and only while the gate is open.
    always_comb begin
        ready_s      = {NUM_REQ{1'b0}};
        accept_s     = 1'b0;
        accept_idx_s = owner_r;
        case (state_r)
            IDLE: begin
                if (gate_s && pick_any_s) begin
                    ready_s      = pick_grant_s;
                    accept_s     = 1'b1;
                    accept_idx_s = pick_idx_s;
                end else begin
                    ready_s  = {NUM_REQ{1'b0}};
                    accept_s = 1'b0;
                end
            end
            BURST: begin
                if (gate_s && owner_valid_s) begin
                    ready_s  = owner_oh_s;
                    accept_s = 1'b1;
                end else begin
                    ready_s  = {NUM_REQ{1'b0}};
                    accept_s = 1'b0;
                end
            end
            default: begin
                ready_s  = {NUM_REQ{1'b0}};
                accept_s = 1'b0;
            end
        endcase
    end

    // Register the accepted beat onto the RAM write port (latency 1).
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            fb_we_r   <= 1'b0;
            fb_addr_r <= {ADDR_W{1'b0}};
            fb_data_r <= {DATA_W{1'b0}};
        end else if (accept_s) begin
            fb_we_r   <= 1'b1;
            fb_addr_r <= req_addr[int'(accept_idx_s) * ADDR_W +: ADDR_W];
            fb_data_r <= req_data[int'(accept_idx_s) * DATA_W +: DATA_W];
        end else begin
            fb_we_r   <= 1'b0;
        end
    end

    // Per-frame write counter: cleared on vblank rise (a coincident beat
    // belongs to the new frame), otherwise saturating count of beats.
    always_ff @(posedge clk_clk or posedge reset_reset) begin
        if (reset_reset) begin
            vblank_q_r <= 1'b0;
            wr_count_r <= 16'd0;
        end else begin
            vblank_q_r <= vblank;
            if (vblank_rise_s) begin
                wr_count_r <= accept_s ? 16'd1 : 16'd0;
            end else if (accept_s && (wr_count_r != 16'hFFFF)) begin
                wr_count_r <= wr_count_r + 16'd1;
            end else begin
                wr_count_r <= wr_count_r;
            end
        end
    end

    assign req_ready = ready_s;
    assign fb_we     = fb_we_r;
    assign fb_addr   = fb_addr_r;
    assign fb_data   = fb_data_r;
    assign wr_count  = wr_count_r;

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed bench for fb_write_arbiter (3 requesters, 16-beat bursts).
// Expected write beats are queued when a grant is expected and checked
// against the registered write port one cycle later.
module tb_fb_write_arbiter;

    localparam int AW = 19;
    localparam int DW = 24;
`ifdef FB_ARB_VBLANK_GATE_EN
    localparam bit GATED = 1'b1;
`else
    localparam bit GATED = 1'b0;
`endif
    localparam logic V_IDLE = GATED;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } beat_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [2:0]        req_valid;
    logic [3*AW-1:0]   req_addr;
    logic [3*DW-1:0]   req_data;
    logic [2:0]        req_ready;
    logic              vblank;
    logic              fb_we;
    logic [AW-1:0]     fb_addr;
    logic [DW-1:0]     fb_data;
    logic [15:0]       wr_count;

    beat_t       q[$];
    int          checks = 0;
    int          errors = 0;
    int          bcnt[3] = '{0, 0, 0};
    logic [15:0] exp_wr = 16'd0;
    logic        vb_prev = 1'b0;

    always #5 clk = ~clk;

    fb_write_arbiter #(
        .NUM_REQ   (3),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .MAX_BURST (16)
    ) dut (
        .clk_clk     (clk),
        .reset_reset (rst),
        .req_valid   (req_valid),
        .req_addr    (req_addr),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .vblank      (vblank),
        .fb_we       (fb_we),
        .fb_addr     (fb_addr),
        .fb_data     (fb_data),
        .wr_count    (wr_count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic beat_t mk_beat(input int i, input int n);
        beat_t b;
        b.a = {i[2:0], n[15:0]};
        b.d = {8'(8'hA0 + i), n[15:0]};
        return b;
    endfunction

    task automatic drive_bus();
        beat_t b;
        for (int i = 0; i < 3; i++) begin
            b = mk_beat(i, bcnt[i]);
            req_addr[i*AW +: AW] = b.a;
            req_data[i*DW +: DW] = b.d;
        end
    endtask

    // One clock: check ready, then after the edge queue the expected beat.
    task automatic cyc(input logic [2:0] exp_rdy, input string tag);
        logic rise;
        #1;
        chk({tag, "/ready"}, 32'(req_ready), 32'(exp_rdy));
        rise    = vblank & ~vb_prev;
        vb_prev = vblank;
        @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            if (exp_rdy[i]) begin
                q.push_back(mk_beat(i, bcnt[i]));
                bcnt[i]++;
            end
        end
        if (rise) begin
            exp_wr = (exp_rdy != 3'b000) ? 16'd1 : 16'd0;
        end else if ((exp_rdy != 3'b000) && (exp_wr != 16'hFFFF)) begin
            exp_wr = exp_wr + 16'd1;
        end
        drive_bus();
    endtask

    // Write-port monitor against the scoreboard.
    always @(negedge clk) begin : mon
        beat_t e;
        logic  ew;
        ew = (q.size() > 0);
        chk("fb_we", 32'(fb_we), 32'(ew));
        if (ew) begin
            e = q.pop_front();
            chk("fb_addr", 32'(fb_addr), 32'(e.a));
            chk("fb_data", 32'(fb_data), 32'(e.d));
        end
        chk("wr_count", 32'(wr_count), 32'(exp_wr));
    end

    // Directed sequence.
    initial begin
        rst       = 1'b1;
        req_valid = 3'b000;
        vblank    = V_IDLE;
        drive_bus();
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_fb_we", 32'(fb_we), 32'd0);
        chk("rst_fb_addr", 32'(fb_addr), 32'd0);
        chk("rst_fb_data", 32'(fb_data), 32'd0);
        chk("rst_wr_count", 32'(wr_count), 32'd0);
        req_valid = 3'b111;
        #1;
        chk("rst_first_pick", 32'(req_ready), 32'd1);
        req_valid = 3'b000;
        rst = 1'b0;

        // 1: all valid, single beats -> 0,1,2 with bubbles between
        req_valid = 3'b111; cyc(3'b001, "t1_g0");
        req_valid = 3'b110; cyc(3'b000, "t1_b0");
        cyc(3'b010, "t1_g1");
        req_valid = 3'b100; cyc(3'b000, "t1_b1");
        cyc(3'b100, "t1_g2");
        req_valid = 3'b000; cyc(3'b000, "t1_b2");
        cyc(3'b000, "t1_idle");

        // 2: burst lock with hand-over to req2 and back to req1
        req_valid = 3'b110;
        for (int i = 0; i < 16; i++) cyc(3'b010, "t2_r1a");
        for (int i = 0; i < 16; i++) cyc(3'b100, "t2_r2");
        for (int i = 0; i < 16; i++) cyc(3'b010, "t2_r1b");
        req_valid = 3'b010;
        for (int i = 0; i < 8; i++) cyc(3'b010, "t2_r1c");
        req_valid = 3'b000; cyc(3'b000, "t2_b");
        cyc(3'b000, "t2_idle");

        // 3: req0 drops at beat 5 -> bubble, then req1 (not req2)
        req_valid = 3'b001;
        for (int i = 0; i < 4; i++) cyc(3'b001, "t3_r0");
        req_valid = 3'b110; cyc(3'b000, "t3_bubble");
        cyc(3'b010, "t3_next");
        req_valid = 3'b000; cyc(3'b000, "t3_b");
        cyc(3'b000, "t3_idle");

        // 4: vblank gating (ungated build keeps granting)
        req_valid = 3'b001;
        vblank    = 1'b0;
        for (int i = 0; i < 3; i++) cyc(GATED ? 3'b000 : 3'b001, "t4_closed");
        vblank = 1'b1;
        for (int i = 0; i < 3; i++) cyc(3'b001, "t4_open");
        vblank = 1'b0; cyc(GATED ? 3'b000 : 3'b001, "t4_fall");
        req_valid = 3'b000; cyc(3'b000, "t4_b");
        vblank = V_IDLE; cyc(3'b000, "t4_idle");

        // 5: wr_count saturation, then vblank rise with a coincident beat
        req_valid = 3'b001;
        for (int i = 0; i < 65540; i++) cyc(3'b001, "t5_run");
        chk("t5_saturated", 32'(wr_count), 32'hFFFF);
        vblank = 1'b0; cyc(GATED ? 3'b000 : 3'b001, "t5_low");
        vblank = 1'b1; cyc(3'b001, "t5_rise");
        chk("t5_after_rise", 32'(wr_count), 32'd1);
        req_valid = 3'b000; cyc(3'b000, "t5_b");
        cyc(3'b000, "t5_idle");

        // 6: asynchronous reset mid-burst
        req_valid = 3'b010;
        for (int i = 0; i < 3; i++) cyc(3'b010, "t6_r1");
        rst = 1'b1;
        #1;
        chk("t6_async_we", 32'(fb_we), 32'd0);
        chk("t6_async_wr", 32'(wr_count), 32'd0);
        q.delete();
        exp_wr    = 16'd0;
        vb_prev   = 1'b0;
        req_valid = 3'b000;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst       = 1'b0;
        req_valid = 3'b011; cyc(3'b001, "t6_first");
        req_valid = 3'b000; cyc(3'b000, "t6_b");
        cyc(3'b000, "t6_idle");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
